lock_attempt_ctrl: RTL
======================

// Module: lock_attempt_ctrl
// PURPOSE
//  Supervisory controller above the combination-lock datapath (switch mux, edge detectors, lock FSM, unlock timer).
//  Drives the datapath clear and counts failed attempts. Enforces an exponential-backoff lockout after each failure.
//  Latches a hard alarm after MAX_TRIES failures; only an admin acknowledge releases it.
// PARAMETERS
//  MAX_TRIES     3      failures that trigger the hard alarm (>=2; must fit in FC_W)
//  LOCKOUT_BASE  1000   lockout length in cycles after the 1st failure (>=1)
//  CNT_W         16     lockout down-counter width
//  FC_W          2      fail_count width
//  DECAY_CYCLES  50000  quiet ARMED cycles per fail_count decrement (only with ATTEMPT_DECAY_EN)
// PORTS
//  clock         in   1     system clock, all logic on posedge
//  reset_n       in   1     synchronous, active-low reset
//  lock_locked   in   1     datapath locked status (1 = locked)
//  lock_alarm_n  in   1     datapath alarm, active-low (0 = wrong code entered)
//  admin_ack     in   1     one-cycle pulse; releases the ALARM state
//  relock        in   1     one-cycle pulse; ends OPEN early
//  lock_clear    out  1     active-high clear to datapath (drives its reset)
//  alarm_out     out  1     hard alarm, active-high
//  lockout       out  1     high while the backoff lockout runs
//  unlocked      out  1     high while the datapath reports unlocked
//  fail_count    out  FC_W  failures since the last success or ack
//  state_dbg     out  3     current state encoding
// BEHAVIOUR
//  States: CLR0=0, CLR1=1, ARMED=2, LOCKOUT=3, ALARM=4, OPEN=5. Moore outputs are decoded from the state register.
//  Reset (reset_n=0 at an edge): state=CLR0, fail_count=0, counters=0.
//   During and after reset: lock_clear=1; all other outputs 0.
//  CLR0: lock_clear=1 -> CLR1. CLR1: lock_clear=0, settle cycle -> ARMED. Datapath inputs are ignored in CLR0/CLR1.
//  ARMED, checked in this priority order:
//   - lock_alarm_n=0: fail_count+1. If the new count == MAX_TRIES -> ALARM; else -> LOCKOUT.
//     On entering LOCKOUT, load cnt = LOCKOUT_BASE << (new_count-1), saturating to 2^CNT_W-1 on overflow.
//   - lock_locked=0 (and no alarm): -> OPEN, fail_count <= 0.
//   - Both asserted in the same cycle: failure path wins.
//  LOCKOUT: lockout=1, lock_clear=1, cnt decrements every cycle.
//   Exactly L cycles in LOCKOUT (L = loaded value), then -> CLR1. Datapath inputs, admin_ack and relock are ignored.
//  ALARM: alarm_out=1, lock_clear=1, fail_count holds MAX_TRIES.
//   admin_ack=1 -> CLR0 with fail_count <= 0. relock is ignored.
//  OPEN: unlocked=1. lock_locked=1 (datapath timer expired) -> ARMED. relock=1 -> CLR0.
//   If both occur in the same cycle, relock wins.
//  Latency: an input sampled at edge N drives the new state/outputs after edge N. No combinational input->output paths.
//  fail_count never wraps; it saturates at MAX_TRIES.
//  Undefined state encodings -> CLR0.
// CONFIGURATION
//  ATTEMPT_DECAY_EN defined: a quiet counter runs only in ARMED and resets on any state exit or failure.
//   When it reaches DECAY_CYCLES with fail_count>0: fail_count decrements by 1 and the quiet counter restarts.
//   It never decrements below 0 and never runs in ALARM.
//  Not defined: no quiet counter is built. fail_count clears only on unlock (OPEN entry), admin_ack, or reset.
// TESTING (bench params: MAX_TRIES=3, LOCKOUT_BASE=4, DECAY_CYCLES=20)
//  1. reset_n=0 for 2 cycles, then 1:
//     lock_clear=1 during reset and the 1st cycle after, 0 on the 2nd; state_dbg=2 on the 3rd cycle.
//  2. ARMED, lock_alarm_n=0 for 1 cycle:
//     fail_count=1; lockout=1 for 4 cycles; then CLR1, ARMED.
//     A 2nd failure gives lockout for 8 cycles; a 3rd gives alarm_out=1 and lock_clear=1.
//  3. In ALARM, hold 100 cycles: alarm_out stays 1; relock has no effect.
//     Pulse admin_ack: CLR0 -> CLR1 -> ARMED, fail_count=0.
//  4. fail_count=1, then lock_locked=0: unlocked=1 and fail_count=0 next cycle.
//     Pulse relock: CLR0. Repeat, letting lock_locked return to 1 instead: ARMED.
//  5. Same-cycle lock_locked=0 & lock_alarm_n=0 in ARMED: LOCKOUT, fail_count+1.
//     lock_alarm_n=0 during LOCKOUT: ignored. reset_n=0 mid-LOCKOUT: fail_count=0, state CLR0.
//  6. With ATTEMPT_DECAY_EN and fail_count=2: after 20 quiet ARMED cycles fail_count=1, after 40 it is 0.
//     Without the macro: fail_count stays at 2.

Source files
------------

// File: rtl/lock_attempt_ctrl.sv
//------------------------------------------------------------------------------
// Module      : lock_attempt_ctrl
// Description : Supervisory controller for the combination-lock datapath:
//               clear sequencing, failed-attempt count, backoff lockout, alarm.
//               Optional fail_count decay is built when ATTEMPT_DECAY_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lock_attempt_ctrl #(
    parameter int MAX_TRIES    = 3,
    parameter int LOCKOUT_BASE = 1000,
    parameter int CNT_W        = 16,
    parameter int FC_W         = 2,
    parameter int DECAY_CYCLES = 50000
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            lock_locked,
    input  logic            lock_alarm_n,
    input  logic            admin_ack,
    input  logic            relock,
    output logic            lock_clear,
    output logic            alarm_out,
    output logic            lockout,
    output logic            unlocked,
    output logic [FC_W-1:0] fail_count,
    output logic [2:0]      state_dbg
);

    localparam logic [2:0] S_CLR0    = 3'd0;
    localparam logic [2:0] S_CLR1    = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_LOCKOUT = 3'd3;
    localparam logic [2:0] S_ALARM   = 3'd4;
    localparam logic [2:0] S_OPEN    = 3'd5;

    localparam logic [FC_W-1:0]  C_MAX_FC   = FC_W'(MAX_TRIES);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
    localparam longint           C_MAX_L    = (64'sd1 <<< CNT_W) - 64'sd1;
    localparam logic [CNT_W-1:0] C_BASE_SAT =
        (longint'(LOCKOUT_BASE) > C_MAX_L) ? C_CNT_MAX : CNT_W'(LOCKOUT_BASE);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [FC_W-1:0]  r_fail_count;
    logic [FC_W-1:0]  w_fc_nxt;
    logic [FC_W-1:0]  w_fc_inc;
    logic [FC_W-1:0]  w_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_load;

`ifdef ATTEMPT_DECAY_EN
    localparam int              C_Q_W    = $clog2(DECAY_CYCLES + 1);
    localparam logic [C_Q_W-1:0] C_Q_LAST = C_Q_W'(DECAY_CYCLES - 1);

    logic [C_Q_W-1:0] r_quiet;
    logic [C_Q_W-1:0] w_quiet_nxt;
    logic             w_quiet_run;
`endif

    assign w_fc_inc = (r_fail_count >= C_MAX_FC) ? C_MAX_FC : r_fail_count + FC_W'(1);
    assign w_shift  = w_fc_inc - FC_W'(1);

    // Doubling with saturation, one step per prior failure.
    always_comb begin
        w_load = C_BASE_SAT;
        for (int i = 0; i < MAX_TRIES; i++) begin
            if (i < int'(w_shift)) begin
                w_load = w_load[CNT_W-1] ? C_CNT_MAX : {w_load[CNT_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= S_CLR0;
            r_fail_count <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_fail_count <= w_fc_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

`ifdef ATTEMPT_DECAY_EN
    // Quiet time accrues only while ARMED sees neither failure nor unlock.
    assign w_quiet_run = (r_state == S_ARMED) && lock_alarm_n && lock_locked;

    always_comb begin
        w_quiet_nxt = '0;
        if (w_quiet_run && (r_quiet != C_Q_LAST)) begin
            w_quiet_nxt = r_quiet + C_Q_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_quiet <= '0;
        end else begin
            r_quiet <= w_quiet_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_fc_nxt    = r_fail_count;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_CLR0: w_state_nxt = S_CLR1;
            S_CLR1: w_state_nxt = S_ARMED;
            S_ARMED: begin
                if (!lock_alarm_n) begin
                    w_fc_nxt = w_fc_inc;
                    if (w_fc_inc == C_MAX_FC) begin
                        w_state_nxt = S_ALARM;
                    end else begin
                        w_state_nxt = S_LOCKOUT;
                        w_cnt_nxt   = w_load;
                    end
                end else if (!lock_locked) begin
                    w_state_nxt = S_OPEN;
                    w_fc_nxt    = '0;
                end
`ifdef ATTEMPT_DECAY_EN
                else if ((r_quiet == C_Q_LAST) && (r_fail_count != '0)) begin
                    w_fc_nxt = r_fail_count - FC_W'(1);
                end
`endif
            end
            S_LOCKOUT: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_CLR1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_ALARM: begin
                if (admin_ack) begin
                    w_state_nxt = S_CLR0;
                    w_fc_nxt    = '0;
                end
            end
            S_OPEN: begin
                if (relock) begin
                    w_state_nxt = S_CLR0;
                end else if (lock_locked) begin
                    w_state_nxt = S_ARMED;
                end
            end
            default: w_state_nxt = S_CLR0;
        endcase
    end

    always_comb begin
        lock_clear = 1'b0;
        alarm_out  = 1'b0;
        lockout    = 1'b0;
        unlocked   = 1'b0;
        case (r_state)
            S_CLR0:    lock_clear = 1'b1;
            S_LOCKOUT: begin
                lock_clear = 1'b1;
                lockout    = 1'b1;
            end
            S_ALARM: begin
                lock_clear = 1'b1;
                alarm_out  = 1'b1;
            end
            S_OPEN:    unlocked = 1'b1;
            default:   lock_clear = 1'b0;
        endcase
    end

    assign fail_count = r_fail_count;
    assign state_dbg  = r_state;

endmodule

`default_nettype wire
